// File: rtl/fnd_scan_decoder.sv
// Receiving end of the scanned 8-digit FND bus: samples seg_com/seg_data, debounces each
// digit dwell, decodes 7-seg patterns to BCD and assembles full frames with error flags.
module fnd_scan_decoder #(
  parameter int STABLE_CYC = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk1k,
  input  logic        sw_reset,
  input  logic [7:0]  seg_com,
  input  logic [7:0]  seg_data,
  output logic [31:0] digits,
  output logic [7:0]  blank_mask,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        com_err,
  output logic        scan_lost
);

  localparam int SW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYC);
  localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT);

  // Result is {bad, blank, nibble}; argument is the segment field without dp.
  function automatic logic [5:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h7E:   seg_decode = 6'h00;
      7'h30:   seg_decode = 6'h01;
      7'h6D:   seg_decode = 6'h02;
      7'h79:   seg_decode = 6'h03;
      7'h33:   seg_decode = 6'h04;
      7'h5B:   seg_decode = 6'h05;
      7'h5F:   seg_decode = 6'h06;
      7'h70:   seg_decode = 6'h07;
      7'h7F:   seg_decode = 6'h08;
      7'h7B:   seg_decode = 6'h09;
      7'h00:   seg_decode = 6'b01_0000;
      default: seg_decode = 6'b10_1111;
    endcase
  endfunction

  function automatic logic is_onehot_low(input logic [7:0] com);
    logic [3:0] n;
    n = 4'd0;
    for (int b = 0; b < 8; b++) n = n + {3'b000, ~com[b]};
    return n == 4'd1;
  endfunction

  function automatic logic [2:0] low_index(input logic [7:0] com);
    logic [2:0] idx;
    idx = 3'd0;
    for (int b = 0; b < 8; b++) if (!com[b]) idx = 3'(b);
    return idx;
  endfunction

  logic [7:0]    r_com_p0;
  logic [6:0]    r_seg_p0;
  logic [14:0]   r_prev_p1;
  logic [SW-1:0] r_stable_p1;
  logic          r_captured_p1;
  logic [31:0]   r_work_dig;
  logic [7:0]    r_work_blank;
  logic [7:0]    r_seen;
  logic [TW-1:0] r_to_cnt;

  logic [14:0] w_key_p0;
  logic        w_changed;
  logic        w_cap;
  logic [7:0]  w_cap_com;
  logic        w_onehot;
  logic        w_store;
  logic [2:0]  w_idx;
  logic [5:0]  w_dec;
  logic [31:0] w_work_dig;
  logic [7:0]  w_work_blank;
  logic [7:0]  w_seen;
  logic        w_complete;
  logic        w_unused_dp;

  assign w_unused_dp = seg_data[0];

  // Stage p0 -> p1: dwell tracking; r_prev_p1 is the value whose run length r_stable_p1 counts
  assign w_key_p0  = {r_com_p0, r_seg_p0};
  assign w_changed = (w_key_p0 != r_prev_p1);
  assign w_cap     = (r_stable_p1 == STABLE_MAX) && !r_captured_p1;
  assign w_cap_com = r_prev_p1[14:7];
  assign w_onehot  = is_onehot_low(w_cap_com);
  assign w_store   = w_cap && w_onehot;
  assign w_idx     = low_index(w_cap_com);
  assign w_dec     = seg_decode(r_prev_p1[6:0]);

  always_comb begin
    w_work_dig   = r_work_dig;
    w_work_blank = r_work_blank;
    w_seen       = r_seen;
    if (w_store) begin
      w_work_dig[{w_idx, 2'b00} +: 4] = w_dec[3:0];
      w_work_blank[w_idx]             = w_dec[4];
      w_seen[w_idx]                   = 1'b1;
    end
  end

  assign w_complete = w_store && (w_seen == 8'hFF);

  always_ff @(posedge clk1k or posedge sw_reset) begin
    if (sw_reset) begin
      r_com_p0      <= 8'hFF;
      r_seg_p0      <= 7'h00;
      r_prev_p1     <= {8'hFF, 7'h00};
      r_stable_p1   <= '0;
      r_captured_p1 <= 1'b0;
      r_work_dig    <= 32'h0;
      r_work_blank  <= 8'h00;
      r_seen        <= 8'h00;
      r_to_cnt      <= '0;
      digits        <= 32'h0;
      blank_mask    <= 8'h00;
      frame_valid   <= 1'b0;
      seg_err       <= 1'b0;
      com_err       <= 1'b0;
    end else begin
      r_com_p0  <= seg_com;
      r_seg_p0  <= seg_data[7:1];
      r_prev_p1 <= w_key_p0;
      if (w_changed) begin
        r_stable_p1   <= SW'(1);
        r_captured_p1 <= 1'b0;
      end else begin
        if (r_stable_p1 != STABLE_MAX) r_stable_p1 <= r_stable_p1 + SW'(1);
        if (w_cap) r_captured_p1 <= 1'b1;
      end
      // Stage p1 -> p2: frame assembly and one-cycle status pulses
      r_work_dig   <= w_work_dig;
      r_work_blank <= w_work_blank;
      r_seen       <= w_complete ? 8'h00 : w_seen;
      frame_valid  <= w_complete;
      seg_err      <= w_store && w_dec[5];
      com_err      <= w_cap && (w_cap_com != 8'hFF) && !w_onehot;
      if (w_complete) begin
        digits     <= w_work_dig;
        blank_mask <= w_work_blank;
        r_to_cnt   <= '0;
      end else if (r_to_cnt != TO_MAX) begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end
    end
  end

  assign scan_lost = (r_to_cnt == TO_MAX);

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Bench for fnd_scan_decoder: directed and randomized digit scans checked against a
// dwell-level reference model of frame assembly, decoding and error reporting.
module tb_fnd_scan_decoder;

  localparam int STABLE = 2;
  localparam int TMO    = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg_com, seg_data;
  logic [31:0] digits;
  logic [7:0]  blank_mask;
  logic        frame_valid, seg_err, com_err, scan_lost;

  always #5 clk = ~clk;

  fnd_scan_decoder #(.STABLE_CYC(STABLE), .TIMEOUT(TMO)) dut (
    .clk1k(clk), .sw_reset(rst), .seg_com(seg_com), .seg_data(seg_data),
    .digits(digits), .blank_mask(blank_mask), .frame_valid(frame_valid),
    .seg_err(seg_err), .com_err(com_err), .scan_lost(scan_lost)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  pat [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

  // Reference model: a run of identical {com, data[7:1]} samples yields one capture
  logic [31:0] m_work;
  logic [7:0]  m_blank, m_seen;
  logic [14:0] m_key;
  int          m_run;
  bit          m_capd;
  logic [39:0] exp_q[$];
  int          exp_seg, exp_com;

  logic [39:0] obs_q[$];
  int          obs_seg = 0, obs_com = 0;
  bit          obs_lost_fv = 1'b0;

  always @(negedge clk) begin
    if (frame_valid) begin
      obs_q.push_back({blank_mask, digits});
      if (scan_lost) obs_lost_fv = 1'b1;
    end
    if (seg_err) obs_seg++;
    if (com_err) obs_com++;
  end

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_work = 32'h0; m_blank = 8'h00; m_seen = 8'h00;
    m_key = {8'hFF, 7'h00}; m_run = 0; m_capd = 1'b0;
    exp_q.delete(); exp_seg = 0; exp_com = 0;
  endtask

  task automatic clear_obs();
    obs_q.delete(); obs_seg = 0; obs_com = 0; obs_lost_fv = 1'b0;
    exp_q.delete(); exp_seg = 0; exp_com = 0;
  endtask

  task automatic model_capture(input logic [7:0] com, input logic [6:0] seg);
    int zeros, idx, val;
    logic [3:0] nib;
    logic blk;
    zeros = 0; idx = 0;
    if (com == 8'hFF) return;
    for (int b = 0; b < 8; b++) if (!com[b]) begin zeros++; idx = b; end
    if (zeros != 1) begin exp_com++; return; end
    val = -1;
    for (int v = 0; v < 10; v++) if (pat[v][7:1] == seg) val = v;
    if (val >= 0) begin nib = 4'(val); blk = 1'b0; end
    else if (seg == 7'h00) begin nib = 4'h0; blk = 1'b1; end
    else begin nib = 4'hF; blk = 1'b0; exp_seg++; end
    m_work[idx*4 +: 4] = nib;
    m_blank[idx] = blk;
    m_seen[idx] = 1'b1;
    if (m_seen == 8'hFF) begin
      exp_q.push_back({m_blank, m_work});
      m_seen = 8'h00;
    end
  endtask

  task automatic dwell(input logic [7:0] com, input logic [7:0] data, input int n);
    logic [14:0] key;
    seg_com = com; seg_data = data;
    repeat (n) @(negedge clk);
    key = {com, data[7:1]};
    if (key == m_key) m_run += n;
    else begin m_key = key; m_run = n; m_capd = 1'b0; end
    if (!m_capd && m_run >= STABLE) begin
      m_capd = 1'b1;
      model_capture(com, data[7:1]);
    end
  endtask

  task automatic scan_digit(input int i, input logic [7:0] data, input int n);
    dwell(~(8'h01 << i), data, n);
  endtask

  task automatic settle_compare(input string tag);
    dwell(8'hFF, 8'h00, 6);
    chk({tag, "_nframes"}, 40'(obs_q.size()), 40'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      chk({tag, "_frame"}, (k < obs_q.size()) ? obs_q[k] : 40'hx, exp_q[k]);
    chk({tag, "_seg_err"}, 40'(obs_seg), 40'(exp_seg));
    chk({tag, "_com_err"}, 40'(obs_com), 40'(exp_com));
  endtask

  function automatic logic [39:0] first_obs();
    return (obs_q.size() > 0) ? obs_q[0] : 40'hx;
  endfunction

  initial begin
    int ord[8];
    int tmp, j, r;
    logic [7:0] d;
    rst = 1'b1; seg_com = 8'hFF; seg_data = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_digits", 40'(digits), 40'h0);
    chk("rst_blank", 40'(blank_mask), 40'h0);
    chk("rst_fv", 40'(frame_valid), 40'h0);
    chk("rst_seg_err", 40'(seg_err), 40'h0);
    chk("rst_com_err", 40'(com_err), 40'h0);
    chk("rst_lost", 40'(scan_lost), 40'h0);
    rst = 1'b0;

    dwell(8'hFF, 8'h00, TMO - 1);
    chk("lost_before_tmo", 40'(scan_lost), 40'h0);
    dwell(8'hFF, 8'h00, 1);
    chk("lost_at_tmo", 40'(scan_lost), 40'h1);

    // Full scan of 1..8
    for (int i = 0; i < 8; i++) scan_digit(i, pat[i + 1], 3);
    settle_compare("scan18");
    chk("scan18_value", first_obs(), {8'h00, 32'h8765_4321});
    chk("lost_at_fv", 40'(obs_lost_fv), 40'h0);
    chk("lost_after_fv", 40'(scan_lost), 40'h0);
    clear_obs();

    // Short dwell on digit 3 is ignored until it is rescanned
    for (int i = 0; i < 8; i++) scan_digit(i, pat[(i + 2) % 10], (i == 3) ? 1 : 3);
    settle_compare("short_dwell");
    chk("short_no_frame", 40'(obs_q.size()), 40'h0);
    scan_digit(3, pat[7], 3);
    settle_compare("short_rescan");
    chk("short_rescan_value", first_obs(), {8'h00, 32'h9876_7432});
    clear_obs();

    // Two commons low at once
    for (int i = 0; i < 6; i++) scan_digit(i, pat[i], 3);
    dwell(8'b1111_1100, pat[9], 4);
    settle_compare("com_bad");
    chk("com_bad_pulses", 40'(obs_com), 40'h1);
    scan_digit(6, pat[6], 3);
    scan_digit(7, pat[7], 3);
    settle_compare("com_bad_done");
    chk("com_bad_value", first_obs(), {8'h00, 32'h7654_3210});
    clear_obs();

    // Undecodable pattern on digit 5, completing digit last
    for (int i = 0; i < 8; i++) if (i != 5) scan_digit(i, pat[1], 3);
    scan_digit(5, 8'h12, 3);
    settle_compare("seg_bad");
    chk("seg_bad_value", first_obs(), {8'h00, 32'h11F1_1111});
    clear_obs();

    // Blank digits 6,7; dp toggling within digit 0 dwell
    scan_digit(0, pat[4] | 8'h01, 1);
    scan_digit(0, pat[4], 1);
    for (int i = 1; i < 6; i++) scan_digit(i, pat[i + 4], 3);
    scan_digit(6, 8'h00, 3);
    scan_digit(7, 8'h01, 3);
    settle_compare("blank");
    chk("blank_value", first_obs(), {8'hC0, 32'h0098_7654});
    clear_obs();

    // Asynchronous reset mid-scan discards the partial frame
    for (int i = 0; i < 5; i++) scan_digit(i, pat[3], 3);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_digits", 40'(digits), 40'h0);
    chk("mid_rst_blank", 40'(blank_mask), 40'h0);
    chk("mid_rst_lost", 40'(scan_lost), 40'h0);
    model_reset();
    clear_obs();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 5; i < 8; i++) scan_digit(i, pat[2], 3);
    settle_compare("post_rst_partial");
    chk("post_rst_no_frame", 40'(obs_q.size()), 40'h0);
    for (int i = 0; i < 8; i++) scan_digit(i, pat[8], 3);
    settle_compare("post_rst_full");
    clear_obs();

    // Randomized scans
    for (int s = 0; s < 25; s++) begin
      for (int i = 0; i < 8; i++) ord[i] = i;
      for (int i = 7; i > 0; i--) begin
        j = int'($urandom_range(i, 0));
        tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
      end
      for (int i = 0; i < 8; i++) begin
        r = int'($urandom_range(11, 0));
        if (r < 10) d = pat[r];
        else if (r == 10) d = 8'h00;
        else d = 8'($urandom);
        d[0] = 1'($urandom);
        scan_digit(ord[i], d, int'($urandom_range(4, 1)));
        if ($urandom_range(9, 0) == 0)
          dwell(8'($urandom), 8'($urandom), int'($urandom_range(3, 1)));
      end
      settle_compare("rand");
      clear_obs();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
